// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: core req/gnt/rvalid port to pipelined SINGLE/NONSEQ AHB transfers.
// Misaligned requests ride the pipeline as IDLE beats so their error stays in order.
module ahb_lite_master #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [DWIDTH-1:0] rdata_o,
  output logic              err_o,
  output logic [1:0]        htrans_o,
  output logic              hwrite_o,
  output logic [2:0]        hsize_o,
  output logic [2:0]        hburst_o,
  output logic [AWIDTH-1:0] haddr_o,
  output logic [DWIDTH-1:0] hwdata_o,
  input  logic [DWIDTH-1:0] hrdata_i,
  input  logic              hready_i,
  input  logic              hresp_i
);

  logic              aph_valid_q, aph_valid_d;
  logic              aph_bad_q,   aph_bad_d;
  logic [AWIDTH-1:0] aph_addr_q,  aph_addr_d;
  logic              aph_write_q, aph_write_d;
  logic [1:0]        aph_size_q,  aph_size_d;
  logic [DWIDTH-1:0] aph_wdata_q, aph_wdata_d;

  logic              dph_valid_q, dph_valid_d;
  logic              dph_bad_q,   dph_bad_d;
  logic              dph_write_q, dph_write_d;
  logic [DWIDTH-1:0] dph_wdata_q, dph_wdata_d;

  logic              rvalid_q, rvalid_d;
  logic              err_q,    err_d;
  logic [DWIDTH-1:0] rdata_q,  rdata_d;

  logic              req_bad;

  assign gnt_o   = req_i && (!aph_valid_q || hready_i);
  assign req_bad = (size_i == 2'd3) ||
                   ((size_i == 2'd1) && addr_i[0]) ||
                   ((size_i == 2'd2) && (addr_i[1:0] != 2'b00));

  always_comb begin
    aph_valid_d = aph_valid_q;
    aph_bad_d   = aph_bad_q;
    aph_addr_d  = aph_addr_q;
    aph_write_d = aph_write_q;
    aph_size_d  = aph_size_q;
    aph_wdata_d = aph_wdata_q;
    dph_valid_d = dph_valid_q;
    dph_bad_d   = dph_bad_q;
    dph_write_d = dph_write_q;
    dph_wdata_d = dph_wdata_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;

    if (hready_i) begin
      dph_valid_d = aph_valid_q;
      dph_bad_d   = aph_bad_q;
      dph_write_d = aph_write_q;
      dph_wdata_d = aph_wdata_q;
      aph_valid_d = 1'b0;
    end

    // gnt implies APH is free or being drained this edge
    if (gnt_o) begin
      aph_valid_d = 1'b1;
      aph_bad_d   = req_bad;
      aph_addr_d  = addr_i;
      aph_write_d = we_i;
      aph_size_d  = size_i;
      aph_wdata_d = wdata_i;
    end

    if (dph_valid_q && hready_i) begin
      rvalid_d = 1'b1;
      err_d    = hresp_i || dph_bad_q;
      if (!dph_write_q) rdata_d = hrdata_i;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      aph_valid_q <= 1'b0;
      aph_bad_q   <= 1'b0;
      aph_addr_q  <= '0;
      aph_write_q <= 1'b0;
      aph_size_q  <= 2'd0;
      aph_wdata_q <= '0;
      dph_valid_q <= 1'b0;
      dph_bad_q   <= 1'b0;
      dph_write_q <= 1'b0;
      dph_wdata_q <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      aph_valid_q <= aph_valid_d;
      aph_bad_q   <= aph_bad_d;
      aph_addr_q  <= aph_addr_d;
      aph_write_q <= aph_write_d;
      aph_size_q  <= aph_size_d;
      aph_wdata_q <= aph_wdata_d;
      dph_valid_q <= dph_valid_d;
      dph_bad_q   <= dph_bad_d;
      dph_write_q <= dph_write_d;
      dph_wdata_q <= dph_wdata_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign htrans_o = (aph_valid_q && !aph_bad_q) ? 2'b10 : 2'b00;
  assign haddr_o  = aph_addr_q;
  assign hwrite_o = aph_write_q;
  assign hsize_o  = {1'b0, aph_size_q};
  assign hburst_o = 3'b000;
  assign hwdata_o = dph_wdata_q;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: random core traffic, a wait/error-injecting AHB slave,
// and an in-order scoreboard fed by a request-level memory model.
module tb_ahb_lite_master;
  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        req_i = 1'b0, we_i = 1'b0;
  logic [1:0]  size_i = 2'd0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        gnt_o, rvalid_o, err_o, hwrite_o;
  logic [31:0] rdata_o, haddr_o, hwdata_o;
  logic [1:0]  htrans_o;
  logic [2:0]  hsize_o, hburst_o;
  logic [31:0] hrdata_i = '0;
  logic        hready_i = 1'b1, hresp_i = 1'b0;

  ahb_lite_master #(.AWIDTH(32), .DWIDTH(32)) dut (
    .hclk(hclk), .hreset(hreset), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o),
    .hsize_o(hsize_o), .hburst_o(hburst_o), .haddr_o(haddr_o), .hwdata_o(hwdata_o),
    .hrdata_i(hrdata_i), .hready_i(hready_i), .hresp_i(hresp_i)
  );

  always #5 hclk = ~hclk;

  typedef struct { logic we; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; int exact; } req_t;
  typedef struct { logic err; logic chk_data; logic [31:0] rdata; int acc_cyc; int exact; } rsp_t;
  typedef struct { logic [31:0] addr; logic we; logic [1:0] size; logic [31:0] wdata; logic err; } bus_t;

  req_t dir_q[$];
  rsp_t exp_q[$];
  bus_t bus_q[$];
  logic [31:0] ref_mem [128];
  logic [31:0] slv_mem [128];

  int n_vec = 0, n_miss = 0, cyc = 0, n_rand = 0, force_wait = -1, n_acc = 0;
  bit idle_stall_en = 1'b0;
  bit pend = 1'b0, accepted = 1'b0;
  req_t cur;
  bus_t s_b;
  bit s_act = 1'b0, s_stage = 1'b0;
  int s_wait = 0;
  bit prev_valid = 1'b0, prev_hready = 1'b1;
  logic [31:0] prev_hwdata = '0;

  always @(posedge hclk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic misaligned(input logic [1:0] s, input logic [31:0] a);
    case (s)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return a[1:0] != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic in_err_region(input logic [31:0] a);
    return a[8:6] == 3'b111;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] s, input logic [1:0] a);
    case (s)
      2'd0:    return 32'h0000_00FF << (8 * a);
      2'd1:    return 32'h0000_FFFF << (8 * a);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic req_t mk(input logic we, input logic [1:0] s, input logic [31:0] a,
                              input logic [31:0] d, input int ex);
    req_t r;
    r.we = we; r.size = s; r.addr = a; r.wdata = d; r.exact = ex;
    return r;
  endfunction

  // Request-level model: each accepted request resolves immediately, in order.
  task automatic model_accept(input req_t r);
    rsp_t e;
    bus_t b;
    logic [31:0] m;
    e.err = 1'b0; e.chk_data = 1'b0; e.rdata = '0; e.acc_cyc = cyc; e.exact = r.exact;
    if (misaligned(r.size, r.addr)) begin
      e.err = 1'b1;
    end else begin
      b.addr = r.addr; b.we = r.we; b.size = r.size; b.wdata = r.wdata;
      b.err = in_err_region(r.addr);
      bus_q.push_back(b);
      if (b.err) e.err = 1'b1;
      else if (r.we) begin
        m = lane_mask(r.size, r.addr[1:0]);
        ref_mem[r.addr[8:2]] = (ref_mem[r.addr[8:2]] & ~m) | (r.wdata & m);
      end else begin
        e.chk_data = 1'b1;
        e.rdata = ref_mem[r.addr[8:2]];
      end
    end
    exp_q.push_back(e);
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.we = 1'($urandom_range(0, 1));
    r.size = ($urandom % 16 == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    r.addr = 32'($urandom_range(0, 511));
    if (r.size != 2'd3 && ($urandom % 8 != 0))
      r.addr = r.addr & ~((32'd1 << r.size) - 32'd1);
    r.wdata = $urandom;
    r.exact = 0;
    return r;
  endfunction

  task automatic drive_slave();
    if (!s_act) begin
      hready_i = idle_stall_en ? ($urandom % 6 != 0) : 1'b1;
      hresp_i  = 1'b0;
      hrdata_i = $urandom;
    end else if (s_wait > 0) begin
      hready_i = 1'b0; hresp_i = 1'b0; hrdata_i = $urandom;
    end else if (s_b.err) begin
      hready_i = s_stage; hresp_i = 1'b1; hrdata_i = $urandom;
    end else begin
      hready_i = 1'b1; hresp_i = 1'b0;
      hrdata_i = s_b.we ? $urandom : slv_mem[s_b.addr[8:2]];
    end
  endtask

  // Core-side driver and AHB slave, both evaluated at the falling edge.
  initial begin
    forever begin
      @(negedge hclk);
      if (hreset) begin
        s_act = 1'b0; s_wait = 0; s_stage = 1'b0;
        pend = 1'b0; accepted = 1'b0; prev_valid = 1'b0;
        @(posedge hclk); #1;
        req_i = 1'b0;
        drive_slave();
        continue;
      end
      if (prev_valid && !prev_hready) check("hwdata_hold", hwdata_o, prev_hwdata);
      if (req_i && !hready_i && htrans_o == 2'b10) check("gnt_aph_full", gnt_o, 0);
      if (req_i && hready_i) check("gnt_ready", gnt_o, 1);
      accepted = req_i && gnt_o;
      if (accepted) begin
        model_accept(cur);
        n_acc++;
      end
      if (hready_i) begin
        if (s_act && s_b.we && !s_b.err) begin
          check("hwdata", hwdata_o, s_b.wdata);
          slv_mem[s_b.addr[8:2]] = (slv_mem[s_b.addr[8:2]] & ~lane_mask(s_b.size, s_b.addr[1:0]))
                                  | (hwdata_o & lane_mask(s_b.size, s_b.addr[1:0]));
        end
        s_act = 1'b0;
        if (htrans_o == 2'b10) begin
          if (bus_q.size() == 0) check("unexpected_bus_xfer", 1, 0);
          else begin
            s_b = bus_q.pop_front();
            check("haddr", haddr_o, s_b.addr);
            check("hwrite", hwrite_o, s_b.we);
            check("hsize", hsize_o, {1'b0, s_b.size});
            s_act = 1'b1; s_stage = 1'b0;
            s_wait = (force_wait >= 0) ? force_wait :
                     (($urandom % 2 == 0) ? 0 : $urandom_range(1, 2));
          end
        end
      end else if (s_act) begin
        if (s_wait > 0) s_wait--;
        else if (s_b.err) s_stage = 1'b1;
      end
      prev_valid = 1'b1; prev_hready = hready_i; prev_hwdata = hwdata_o;
      @(posedge hclk); #1;
      if (accepted) pend = 1'b0;
      if (!pend) begin
        if (dir_q.size() != 0) begin cur = dir_q.pop_front(); pend = 1'b1; end
        else if (n_rand > 0 && ($urandom % 4 != 0)) begin cur = rand_req(); n_rand--; pend = 1'b1; end
      end
      req_i = pend; we_i = cur.we; size_i = cur.size; addr_i = cur.addr; wdata_i = cur.wdata;
      drive_slave();
    end
  end

  // Response monitor: pops the scoreboard on every rvalid_o pulse.
  initial begin
    rsp_t e;
    forever begin
      @(negedge hclk);
      if (hreset || !rvalid_o) continue;
      if (exp_q.size() == 0) check("unexpected_rvalid", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("err", err_o, e.err);
        if (e.chk_data) check("rdata", rdata_o, e.rdata);
        if (e.exact != 0) check("latency", cyc - e.acc_cyc, 3);
        else check("latency_min", (cyc - e.acc_cyc) >= 3, 1);
      end
    end
  end

  task automatic drain(input int lim);
    int t = 0;
    while ((dir_q.size() != 0 || pend || exp_q.size() != 0) && t < lim) begin
      @(negedge hclk);
      t++;
    end
    check("drain_timeout", t < lim, 1);
  endtask

  initial begin
    int base;
    int t;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    ref_mem[32'h100 >> 2] = 32'hDEADBEEF;
    slv_mem[32'h100 >> 2] = 32'hDEADBEEF;

    repeat (2) @(posedge hclk);
    #2;
    check("rst_htrans", htrans_o, 2'b00);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_haddr", haddr_o, 0);
    check("rst_hwdata", hwdata_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_hwrite", hwrite_o, 0);
    check("rst_hsize", hsize_o, 0);
    check("hburst", hburst_o, 0);
    @(posedge hclk); #1;
    hreset = 1'b0;

    force_wait = 0;
    dir_q.push_back(mk(1'b0, 2'd2, 32'h100, 32'h0, 1));
    drain(50);
    dir_q.push_back(mk(1'b1, 2'd2, 32'h200, 32'h12345678, 0));
    dir_q.push_back(mk(1'b0, 2'd2, 32'h204, 32'h0, 0));
    drain(50);
    force_wait = 2;
    dir_q.push_back(mk(1'b0, 2'd2, 32'h200, 32'h0, 0));
    dir_q.push_back(mk(1'b0, 2'd2, 32'h100, 32'h0, 0));
    drain(50);
    force_wait = 0;
    dir_q.push_back(mk(1'b0, 2'd2, 32'h1C0, 32'h0, 0));
    dir_q.push_back(mk(1'b0, 2'd2, 32'h100, 32'h0, 0));
    drain(50);
    dir_q.push_back(mk(1'b0, 2'd1, 32'h101, 32'h0, 0));
    dir_q.push_back(mk(1'b0, 2'd2, 32'h104, 32'h0, 0));
    drain(50);

    force_wait = -1;
    idle_stall_en = 1'b1;
    n_rand = 400;
    t = 0;
    while (n_rand > 0 && t < 20000) begin @(negedge hclk); t++; end
    drain(5000);
    check("bus_q_empty", bus_q.size(), 0);

    // Reset while a read data phase stalls with a second read waiting in APH.
    idle_stall_en = 1'b0;
    force_wait = 20;
    base = n_acc;
    dir_q.push_back(mk(1'b0, 2'd2, 32'h100, 32'h0, 0));
    dir_q.push_back(mk(1'b0, 2'd2, 32'h104, 32'h0, 0));
    t = 0;
    while (n_acc < base + 2 && t < 100) begin @(negedge hclk); t++; end
    check("reset_setup_timeout", t < 100, 1);
    @(posedge hclk); #2;
    check("pre_reset_htrans", htrans_o, 2'b10);
    hreset = 1'b1;
    #1;
    check("reset_htrans_idle", htrans_o, 2'b00);
    check("reset_rvalid", rvalid_o, 0);
    exp_q.delete();
    bus_q.delete();
    repeat (2) @(posedge hclk);
    #1;
    hreset = 1'b0;
    repeat (10) @(negedge hclk);
    force_wait = 0;
    dir_q.push_back(mk(1'b0, 2'd2, 32'h104, 32'h0, 1));
    drain(50);
    check("final_bus_q_empty", bus_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_miss);
    $fatal(1);
  end

endmodule
